// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous-read memory between instruction fetch and data
// load/store. Data has priority, bounded by a starvation counter that forces an instruction grant.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_gnt,
  output logic              i_rvalid,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_ce,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_e;

  owner_e           owner_q, owner_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             starved_s;

  assign starved_s = i_req && (starve_cnt_q == STARVE_LIM);

  // Grant selection: data first unless instruction has waited STARVE_MAX data grants.
  always_comb begin
    i_gnt = 1'b0;
    d_gnt = 1'b0;
    if (!rst) begin
      i_gnt = 1'b0;
      d_gnt = 1'b0;
    end else if (d_req && !starved_s) begin
      d_gnt = 1'b1;
    end else if (i_req) begin
      i_gnt = 1'b1;
    end else begin
      i_gnt = 1'b0;
      d_gnt = 1'b0;
    end
  end

  // Memory command mux; every command field is zero on idle cycles.
  always_comb begin
    m_ce    = i_gnt | d_gnt;
    m_we    = 1'b0;
    m_addr  = {ADDR_W{1'b0}};
    m_wdata = {DATA_W{1'b0}};
    if (d_gnt) begin
      m_we    = d_we;
      m_addr  = d_addr;
      m_wdata = d_wdata;
    end else if (i_gnt) begin
      m_addr  = i_addr;
    end else begin
      m_we    = 1'b0;
    end
  end

  // Next response owner and starvation count.
  always_comb begin
    owner_d      = OWN_NONE;
    starve_cnt_d = starve_cnt_q;
    if (i_gnt) begin
      owner_d = OWN_INST;
    end else if (d_gnt && !d_we) begin
      owner_d = OWN_DATA;
    end else begin
      owner_d = OWN_NONE;
    end
    if (i_gnt || !i_req) begin
      starve_cnt_d = {CNT_W{1'b0}};
    end else if (d_gnt && (starve_cnt_q != STARVE_LIM)) begin
      starve_cnt_d = starve_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      starve_cnt_d = starve_cnt_q;
    end
  end

  // State registers; reset discards any in-flight read response.
  always_ff @(posedge clk) begin
    if (!rst) begin
      owner_q      <= OWN_NONE;
      starve_cnt_q <= {CNT_W{1'b0}};
    end else begin
      owner_q      <= owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  assign i_rvalid = rst && (owner_q == OWN_INST);
  assign d_rvalid = rst && (owner_q == OWN_DATA);
  assign i_rdata  = i_rvalid ? m_rdata : {DATA_W{1'b0}};
  assign d_rdata  = d_rvalid ? m_rdata : {DATA_W{1'b0}};

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter with a small synchronous-read memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, i_gnt, i_rvalid;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_we, d_gnt, d_rvalid;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        m_ce, m_we;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int pass_cnt  = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_ce(m_ce), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  // Memory model: preloaded words until overwritten.
  logic [31:0] mem     [0:255];
  logic        written [0:255];

  function automatic logic [31:0] init_word(input logic [7:0] a);
    case (a)
      8'h10:   init_word = 32'h0050_0093;
      8'h14:   init_word = 32'hA5A5_0014;
      8'h40:   init_word = 32'h1234_5678;
      default: init_word = {24'h00_0000, a};
    endcase
  endfunction

  always @(posedge clk) begin
    if (m_ce && m_we) begin
      mem[m_addr[7:0]]     <= m_wdata;
      written[m_addr[7:0]] <= 1'b1;
    end else if (m_ce) begin
      m_rdata <= (written[m_addr[7:0]] === 1'b1) ? mem[m_addr[7:0]] : init_word(m_addr[7:0]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
  endtask

  task automatic test_reset();
    rst = 1'b0; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
    i_addr = 32'h10; d_addr = 32'h40; d_wdata = 32'h0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total_cnt++;
      if ({i_gnt, d_gnt, m_ce, i_rvalid, d_rvalid} !== 5'b00000)
        $display("FAIL reset_hold cyc%0d: got %b expected 00000", k, {i_gnt, d_gnt, m_ce, i_rvalid, d_rvalid});
      else pass_cnt++;
      total_cnt++;
      if ({m_addr, m_wdata, i_rdata, d_rdata} !== 128'h0)
        $display("FAIL reset_buses cyc%0d: got %h expected 0", k, {m_addr, m_wdata, i_rdata, d_rdata});
      else pass_cnt++;
      step();
    end
    rst = 1'b1;
    @(negedge clk);
    total_cnt++;
    if ({i_gnt, d_gnt} !== 2'b01) $display("FAIL reset_release: got %b expected 01", {i_gnt, d_gnt});
    else pass_cnt++;
    step(); idle(); step(); step();
  endtask

  task automatic test_inst_read();
    i_req = 1'b1; i_addr = 32'h10;
    @(negedge clk);
    total_cnt++;
    if ({i_gnt, d_gnt, m_ce, m_we} !== 4'b1010) $display("FAIL iread_gnt: got %b expected 1010", {i_gnt, d_gnt, m_ce, m_we});
    else pass_cnt++;
    total_cnt++;
    if (m_addr !== 32'h10) $display("FAIL iread_maddr: got %h expected 00000010", m_addr);
    else pass_cnt++;
    step(); idle();
    @(negedge clk);
    total_cnt++;
    if ({i_rvalid, d_rvalid} !== 2'b10) $display("FAIL iread_rvalid: got %b expected 10", {i_rvalid, d_rvalid});
    else pass_cnt++;
    total_cnt++;
    if (i_rdata !== 32'h0050_0093 || d_rdata !== 32'h0) $display("FAIL iread_rdata: got %h/%h expected 00500093/00000000", i_rdata, d_rdata);
    else pass_cnt++;
    step();
  endtask

  task automatic test_contention();
    i_req = 1'b1; i_addr = 32'h14; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    @(negedge clk);
    total_cnt++;
    if ({i_gnt, d_gnt, m_addr} !== {2'b01, 32'h40}) $display("FAIL cont_dfirst: got %b %h expected 01 00000040", {i_gnt, d_gnt}, m_addr);
    else pass_cnt++;
    step(); d_req = 1'b0;
    @(negedge clk);
    total_cnt++;
    if ({i_gnt, d_gnt, m_addr} !== {2'b10, 32'h14}) $display("FAIL cont_ithen: got %b %h expected 10 00000014", {i_gnt, d_gnt}, m_addr);
    else pass_cnt++;
    total_cnt++;
    if ({d_rvalid, i_rvalid, d_rdata} !== {2'b10, 32'h1234_5678}) $display("FAIL cont_dresp: got %b %h expected 10 12345678", {d_rvalid, i_rvalid}, d_rdata);
    else pass_cnt++;
    step(); idle();
    @(negedge clk);
    total_cnt++;
    if ({i_rvalid, d_rvalid, i_rdata} !== {2'b10, 32'hA5A5_0014}) $display("FAIL cont_iresp: got %b %h expected 10 a5a50014", {i_rvalid, d_rvalid}, i_rdata);
    else pass_cnt++;
    step();
  endtask

  task automatic test_starvation();
    logic [11:0] exp_d;
    logic        prev_d, prev_i;
    exp_d  = 12'b1101_1110_1111;
    prev_d = 1'b0; prev_i = 1'b0;
    i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      total_cnt++;
      if ({i_gnt, d_gnt} !== {~exp_d[k], exp_d[k]})
        $display("FAIL starve_gnt cyc%0d: got %b expected %b", k, {i_gnt, d_gnt}, {~exp_d[k], exp_d[k]});
      else pass_cnt++;
      total_cnt++;
      if ({i_rvalid, d_rvalid} !== {prev_i, prev_d})
        $display("FAIL starve_owner cyc%0d: got %b expected %b", k, {i_rvalid, d_rvalid}, {prev_i, prev_d});
      else pass_cnt++;
      prev_d = exp_d[k]; prev_i = ~exp_d[k];
      step();
    end
    idle(); step(); step();
  endtask

  task automatic test_read_then_write();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    step();
    d_we = 1'b1; d_addr = 32'h24; d_wdata = 32'h0BAD_F00D;
    @(negedge clk);
    total_cnt++;
    if ({d_gnt, m_we, d_rvalid, d_rdata} !== {3'b111, 32'h1234_5678})
      $display("FAIL rw_coexist: got %b %h expected 111 12345678", {d_gnt, m_we, d_rvalid}, d_rdata);
    else pass_cnt++;
    step(); idle();
    @(negedge clk);
    total_cnt++;
    if ({d_rvalid, i_rvalid, m_ce} !== 3'b000) $display("FAIL rw_noresp: got %b expected 000", {d_rvalid, i_rvalid, m_ce});
    else pass_cnt++;
    step();
  endtask

  task automatic test_write_read();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
    @(negedge clk);
    total_cnt++;
    if ({d_gnt, m_ce, m_we, m_addr, m_wdata} !== {3'b111, 32'h20, 32'hDEAD_BEEF})
      $display("FAIL wr_cmd: got %b %h %h expected 111 00000020 deadbeef", {d_gnt, m_ce, m_we}, m_addr, m_wdata);
    else pass_cnt++;
    step(); d_we = 1'b0; d_wdata = 32'h0;
    @(negedge clk);
    total_cnt++;
    if ({d_gnt, m_we, d_rvalid} !== 3'b100) $display("FAIL wr_rdcmd: got %b expected 100", {d_gnt, m_we, d_rvalid});
    else pass_cnt++;
    step(); idle();
    @(negedge clk);
    total_cnt++;
    if ({d_rvalid, d_rdata} !== {1'b1, 32'hDEAD_BEEF}) $display("FAIL wr_readback: got %b %h expected 1 deadbeef", d_rvalid, d_rdata);
    else pass_cnt++;
    total_cnt++;
    if ({m_ce, m_we, m_addr, m_wdata} !== 66'h0) $display("FAIL idle_cmd: got %h expected 0", {m_ce, m_we, m_addr, m_wdata});
    else pass_cnt++;
    step();
  endtask

  task automatic test_reset_mid_read();
    logic [4:0] exp_d;
    exp_d = 5'b01111;
    i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    step(); step(); step();
    @(negedge clk);
    total_cnt++;
    if (d_gnt !== 1'b1) $display("FAIL rmid_gnt: got %b expected 1", d_gnt);
    else pass_cnt++;
    rst = 1'b0;
    step();
    rst = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 0) begin
        total_cnt++;
        if ({d_rvalid, i_rvalid} !== 2'b00) $display("FAIL rmid_rvalid: got %b expected 00", {d_rvalid, i_rvalid});
        else pass_cnt++;
      end
      total_cnt++;
      if ({i_gnt, d_gnt} !== {~exp_d[k], exp_d[k]})
        $display("FAIL rmid_cnt cyc%0d: got %b expected %b", k, {i_gnt, d_gnt}, {~exp_d[k], exp_d[k]});
      else pass_cnt++;
      step();
    end
    idle(); step();
  endtask

  initial begin
    idle();
    rst = 1'b0;
    #1;
    test_reset();
    test_inst_read();
    test_contention();
    test_starvation();
    test_read_then_write();
    test_write_read();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter that shares one single-port, synchronous-read memory between the core's instruction-fetch port and its data load/store port. It sits between `riscv` and a unified instruction/data memory. Data accesses have fixed priority, bounded by a starvation counter that forces an instruction grant. It issues at most one memory command per cycle and routes each read response back to the requester that issued it.

## Interface
- `ADDR_W`, 32, address width of both requesters and the memory.
- `DATA_W`, 32, data width.
- `STARVE_MAX`, 4, maximum consecutive data grants while `i_req` is pending before instruction is forced (≥1).

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `i_req`  in  1  instruction read request.
- `i_addr`  in  ADDR_W  instruction address.
- `i_gnt`  out  1  instruction request accepted this cycle.
- `i_rvalid`  out  1  instruction read data valid.
- `i_rdata`  out  DATA_W  instruction read data.
- `d_req`  in  1  data request.
- `d_we`  in  1  data write enable; 1 = write, 0 = read.
- `d_addr`  in  ADDR_W  data address.
- `d_wdata`  in  DATA_W  data write value.
- `d_gnt`  out  1  data request accepted this cycle.
- `d_rvalid`  out  1  data read data valid.
- `d_rdata`  out  DATA_W  data read data.
- `m_ce`  out  1  memory chip enable.
- `m_we`  out  1  memory write enable.
- `m_addr`  out  ADDR_W  memory address.
- `m_wdata`  out  DATA_W  memory write data.
- `m_rdata`  in  DATA_W  memory read data, valid the cycle after a read command.

## Operation
- Requester rule: hold `req`, `addr`, `we` and `wdata` stable until `gnt` is seen high at a clock edge. The arbiter does not buffer requests.
- **Grant logic** (combinational, same cycle). It is forced to 0 while `rst`=0.
  - `d_req` && !(`i_req` && `starve_cnt`==STARVE_MAX) → `d_gnt`=1.
  - Else, `i_req` → `i_gnt`=1.
  - `i_gnt` and `d_gnt` are never both 1.
- **Memory command**:
  - `m_ce` = `i_gnt`|`d_gnt`.
  - `m_addr`/`m_we`/`m_wdata` are muxed from the granted requester.
  - `m_we`=`d_gnt`&`d_we`; it is always 0 on instruction grants.
  - When `m_ce`=0, `m_addr`, `m_wdata` and `m_we` are 0.
- **Response owner register** `owner` ∈ {NONE, INST, DATA}. Reset value is NONE. At each edge:
  - INST if `i_gnt`.
  - DATA if `d_gnt`&!`d_we`.
  - Else NONE.
- **Read-data outputs**:
  - `i_rvalid`=(`owner`==INST); `d_rvalid`=(`owner`==DATA).
  - `x_rdata` = `m_rdata` when the matching `rvalid` is 1, else 0.
- **Starvation counter** `starve_cnt`, width clog2(STARVE_MAX+1). At each edge:
  - 0 if `i_gnt` or !`i_req`.
  - +1 if `d_gnt`&&`i_req`, saturating at STARVE_MAX.
  - Else hold.
- Writes produce no `rvalid`.
- Simultaneous events:
  - A write grant in cycle N and any read response from cycle N-1 coexist. The owner of the response is the one registered at cycle N-1.
  - A new grant may issue in the same cycle a response is delivered.
- Reset mid-operation:
  - While `rst`=0, grants and `m_ce` are forced to 0.
  - At the first edge with `rst`=0, `owner` goes to NONE and `starve_cnt` to 0, so any in-flight read response is discarded.

## Timing
- Reset values: `i_gnt`, `d_gnt`, `m_ce`, `m_we`, `i_rvalid`, `d_rvalid` = 0; `m_addr`, `m_wdata`, `i_rdata`, `d_rdata` = 0.
- Grant latency: 0 cycles (combinational from `req`).
- Read latency: request granted in cycle N → `rvalid`=1 and data valid in cycle N+1, for exactly one cycle.
- Throughput: one command per cycle; back-to-back reads from either or both requesters are sustained.
- Write: committed to memory at the edge ending the grant cycle; a read granted in the next cycle returns the new value.
- Worst-case instruction wait under continuous data traffic: STARVE_MAX cycles.

## Test plan
- Reset:
  - Stimulus: `rst`=0 for 3 cycles with `i_req`=`d_req`=1.
  - Required: `i_gnt`, `d_gnt`, `m_ce` and both `rvalid` stay 0 throughout.
  - Required: the first cycle after release gives `d_gnt`=1.
- Instruction read:
  - Stimulus: `i_req`=1, `i_addr`=0x10, memory[0x10]=0x00500093.
  - Required: `i_gnt`=1 and `m_addr`=0x10 in cycle N.
  - Required: `i_rvalid`=1 and `i_rdata`=0x00500093 in N+1; `d_rvalid`=0.
- Contention:
  - Stimulus: `i_req` and `d_req` (read, addr 0x40) asserted together.
  - Required: `d_gnt`=1 and `i_gnt`=0.
  - Required: after `d_req` drops, `i_gnt`=1 the next cycle.
  - Required: `d_rvalid` then `i_rvalid` in consecutive cycles.
- Starvation, STARVE_MAX=4:
  - Stimulus: `i_req` and `d_req` held high for 12 cycles.
  - Required grant sequence: D,D,D,D,I,D,D,D,D,I,D,D.
- Write then read:
  - Stimulus: `d_we`=1, `d_addr`=0x20, `d_wdata`=0xDEADBEEF, then a read of 0x20 next cycle.
  - Required: `m_we`=1 only in the write cycle; no `d_rvalid` for the write.
  - Required: the following read returns `d_rdata`=0xDEADBEEF.
- Reset mid-read:
  - Stimulus: data read granted in cycle N, `rst`=0 sampled at the end of N.
  - Required: `d_rvalid`=0 in N+1 and `starve_cnt`=0.
